// File: rtl/mul_div_unit_if.sv
// Operand/strobe/result bundle between the EX-stage issue logic and the
// iterative multiply/divide unit.
interface mul_div_unit_if;
  logic        mul_i;
  logic        div_i;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        stall_o;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport master (
    output mul_i, div_i, src_a, src_b,
    input  stall_o, done_o, hi_o, lo_o
  );

  modport slave (
    input  mul_i, div_i, src_a, src_b,
    output stall_o, done_o, hi_o, lo_o
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative signed mult/div (32 iterations on magnitudes) writing HI/LO,
// stalling the pipeline while an operation is in flight.
module mul_div_unit (
  input  logic          clk,
  input  logic          rst_n,
  mul_div_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        op_div_q, op_div_d;
  logic        neg_q, neg_d;
  logic        rem_neg_q, rem_neg_d;
  logic [31:0] opnd_q, opnd_d;
  logic [63:0] work_q, work_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        start;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] add_sum;
  logic [32:0] sub_diff;
  logic [63:0] shl;
  logic [63:0] step;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      op_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      opnd_q    <= 32'd0;
      work_q    <= 64'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_div_q  <= op_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      opnd_q    <= opnd_d;
      work_q    <= work_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.mul_i || bus.div_i) state_d = RUN;
      RUN:     if (cnt_q == 5'd31) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign start = (state_q == IDLE) && (bus.mul_i || bus.div_i);
  assign abs_a = bus.src_a[31] ? (~bus.src_a + 32'd1) : bus.src_a;
  assign abs_b = bus.src_b[31] ? (~bus.src_b + 32'd1) : bus.src_b;

  // Multiply: add multiplicand into the upper half when the low bit is set, then shift right.
  assign add_sum = {1'b0, work_q[63:32]} + {1'b0, (work_q[0] ? opnd_q : 32'd0)};
  // Divide: shift left, trial-subtract divisor from the upper half, keep it if non-negative.
  assign shl      = {work_q[62:0], 1'b0};
  assign sub_diff = {1'b0, shl[63:32]} - {1'b0, opnd_q};

  always_comb begin
    step = {add_sum, work_q[31:1]};
    if (op_div_q) begin
      step = sub_diff[32] ? shl : {sub_diff[31:0], shl[31:1], 1'b1};
    end
  end

  assign prod_fix = neg_q ? (~step + 64'd1) : step;
  assign quo_fix  = neg_q ? (~step[31:0] + 32'd1) : step[31:0];
  assign rem_fix  = rem_neg_q ? (~step[63:32] + 32'd1) : step[63:32];

  always_comb begin
    cnt_d     = cnt_q;
    op_div_d  = op_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    opnd_d    = opnd_q;
    work_d    = work_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    if (start) begin
      cnt_d     = 5'd0;
      op_div_d  = !bus.mul_i;
      rem_neg_d = bus.src_a[31];
      if (bus.mul_i) begin
        opnd_d = abs_a;
        work_d = {32'd0, abs_b};
        neg_d  = bus.src_a[31] ^ bus.src_b[31];
      end else begin
        opnd_d = abs_b;
        work_d = {32'd0, abs_a};
        // A zero divisor yields an all-ones quotient that must not be negated.
        neg_d  = (bus.src_a[31] ^ bus.src_b[31]) && (bus.src_b != 32'd0);
      end
    end else if (state_q == RUN) begin
      work_d = step;
      cnt_d  = cnt_q + 5'd1;
      if (cnt_q == 5'd31) begin
        if (op_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end
      end
    end
  end

  always_comb begin
    bus.stall_o = 1'b0;
    bus.done_o  = 1'b0;
    case (state_q)
      IDLE:    bus.stall_o = bus.mul_i || bus.div_i;
      RUN:     bus.stall_o = 1'b1;
      DONE:    bus.done_o  = 1'b1;
      default: bus.stall_o = 1'b0;
    endcase
  end

  assign bus.hi_o = hi_q;
  assign bus.lo_o = lo_q;

endmodule
